// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared definitions for the serial link (UART transmitter and
//                receiver): data width, receiver state encoding and the
//                half-bit timing helper.
//  Contents    : UART_DATA_BITS   - bits per UART character
//                uart_rx_state_t  - receiver FSM state encoding
//                uart_half_bit()  - half a bit period in clock cycles
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        UART_RX_IDLE      = 3'd0,
        UART_RX_START     = 3'd1,
        UART_RX_DATA      = 3'd2,
        UART_RX_STOP      = 3'd3,
        UART_RX_WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    // Integer division: an odd bit period rounds the midpoint down.
    function automatic int uart_half_bit(input int cpb);
        return cpb / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for asynchronous inputs. The reset
//                value is a parameter so idle-high lines (UART rx) do not
//                produce a spurious edge when reset is released.
//  Ports       : clk  - destination clock
//                rst  - synchronous reset, active low
//                d    - asynchronous input
//                q    - synchronised output (two clocks of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Synchronises rx, validates the start bit
//                at its midpoint, samples each data bit at its midpoint (LSB
//                first) and presents the byte on a valid/ready handshake.
//                Flags framing errors (stop bit low) and overruns.
//  Parameters  : CLOCKS_PER_BIT - clock cycles per UART bit, must be >= 4
//  Ports       : clk       - system clock
//                rst       - synchronous reset, active low
//                rx        - asynchronous serial line, idles high
//                data      - received byte, stable while valid is high
//                valid     - data holds an unconsumed byte
//                ready     - consumer accepts data when valid && ready
//                busy      - receiver FSM is not idle
//                frame_err - one-cycle pulse, stop bit sampled low
//                overrun   - a completed byte was dropped (sticky until accept)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    import serial_pkg::*;

    localparam int c_HALF   = uart_half_bit(CLOCKS_PER_BIT);
    localparam int c_CNT_W  = $clog2(CLOCKS_PER_BIT);
    localparam int c_IDX_W  = $clog2(UART_DATA_BITS);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(c_HALF - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(UART_DATA_BITS - 1);

    localparam logic [2:0] c_IDLE      = 3'(UART_RX_IDLE);
    localparam logic [2:0] c_START     = 3'(UART_RX_START);
    localparam logic [2:0] c_DATA      = 3'(UART_RX_DATA);
    localparam logic [2:0] c_STOP      = 3'(UART_RX_STOP);
    localparam logic [2:0] c_WAIT_HIGH = 3'(UART_RX_WAIT_HIGH);

    // ------------------------------------------------------------------
    // Input synchroniser (idle-high line, so reset value is 1)
    // ------------------------------------------------------------------
    logic w_rx_s;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (w_rx_s)
    );

    // ------------------------------------------------------------------
    // Receive FSM, bit-period counter, bit index and shift register
    // ------------------------------------------------------------------
    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_CNT_W-1:0]        w_cnt_nxt;
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_IDX_W-1:0]        w_idx_nxt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_nxt;
    logic                      w_cnt_last;
    logic                      w_done;
    logic                      w_bad;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_last ? '0 : r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_bad       = 1'b0;

        case (r_state)
            c_IDLE: begin
                // Counter held at zero so START begins a fresh half-bit count.
                w_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = c_START;
                end
            end

            c_START: begin
                if (r_cnt == c_CNT_MID) begin
                    if (w_rx_s) begin
                        w_state_nxt = c_IDLE;
                    end else begin
                        // From here every sample lands on a bit midpoint.
                        w_state_nxt = c_DATA;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end
                end
            end

            c_DATA: begin
                if (w_cnt_last) begin
                    w_shift_nxt = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    w_idx_nxt   = r_idx + 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = c_STOP;
                        w_cnt_nxt   = '0;
                    end
                end
            end

            c_STOP: begin
                // Leaving at mid-stop-bit rearms the receiver half a bit
                // early so back-to-back frames lose no cycles.
                if (w_cnt_last) begin
                    if (w_rx_s) begin
                        w_done      = 1'b1;
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = c_WAIT_HIGH;
                    end
                end
            end

            c_WAIT_HIGH: begin
                // A held-low line (break) must not be taken as a new start.
                if (w_rx_s) begin
                    w_state_nxt = c_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Stop-sample events are registered once more so every output is a
    // flop fed only from other flops.
    logic r_done;
    logic r_bad;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_done  <= w_done;
            r_bad   <= w_bad;
        end
    end

    // ------------------------------------------------------------------
    // Output register and valid/ready handshake
    // ------------------------------------------------------------------
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_busy;
    logic                      r_frame_err;
    logic                      r_overrun;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Derived from the next state so busy rises together with START.
            r_busy      <= (w_state_nxt != c_IDLE);
            r_frame_err <= r_bad;

            if (r_done && (!r_valid || ready)) begin
                // Slot free, or being freed by an accept this very cycle.
                r_data    <= r_shift;
                r_valid   <= 1'b1;
                r_overrun <= 1'b0;
            end else if (r_done) begin
                // Slot still occupied: keep the old byte, drop the new one.
                r_overrun <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking testbench for uart_rx with CLOCKS_PER_BIT=10.
//                A bench-side 8N1 serial driver stands in for the hello_world
//                transmitter; a negedge monitor records valid rising edges,
//                frame_err pulses and busy/valid high cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB     = 10;
    localparam int LATENCY = 98;   // 3 + CPB/2 + 9*CPB

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLOCKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Number of posedges so far; at a negedge the next posedge has index cyc.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] d;
    } rec_t;

    rec_t rises[$];
    int   ferrs[$];
    int   vhigh = 0;
    int   bhigh = 0;
    logic vprev = 1'b0;

    always @(negedge clk) begin
        if (valid && !vprev) rises.push_back('{cyc - 1, data});
        vprev = valid;
        if (valid) vhigh++;
        if (busy) bhigh++;
        if (frame_err) ferrs.push_back(cyc - 1);
    end

    int checks = 0;
    int errors = 0;

    // Starts on a negedge, ends on a negedge with rx left at the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop_v,
                             input int stop_len, output int t0);
        t0 = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_v;
        repeat (stop_len) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00)   begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int t0;
        int r0 = rises.size();
        int f0 = ferrs.size();
        int v0 = vhigh;
        ready = 1'b1;
        send_byte(8'h48, 1'b1, CPB, t0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rises.size() - r0 !== 1) begin
            errors++; $display("FAIL single_count got %0d want 1", rises.size() - r0);
        end else begin
            checks++; if (rises[r0].c !== t0 + LATENCY) begin errors++; $display("FAIL single_cycle got %0d want %0d", rises[r0].c - t0, LATENCY); end
            checks++; if (rises[r0].d !== 8'h48) begin errors++; $display("FAIL single_data got %h want 48", rises[r0].d); end
        end
        checks++; if (vhigh - v0 !== 1) begin errors++; $display("FAIL single_valid_width got %0d want 1", vhigh - v0); end
        checks++; if (ferrs.size() !== f0) begin errors++; $display("FAIL single_frame_err got %0d pulses want 0", ferrs.size() - f0); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL single_overrun got %b want 0", overrun); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        int t0;
        int tfirst = 0;
        int r0 = rises.size();
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_byte(msg[i], 1'b1, CPB, t0);
            if (i == 0) tfirst = t0;
        end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rises.size() - r0 !== 5) begin
            errors++; $display("FAIL b2b_count got %0d want 5", rises.size() - r0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rises[r0+i].d !== msg[i] || rises[r0+i].c !== tfirst + LATENCY + 100*i) begin
                    errors++;
                    $display("FAIL b2b_byte%0d got %h at %0d want %h at %0d", i, rises[r0+i].d,
                             rises[r0+i].c - tfirst, msg[i], LATENCY + 100*i);
                end
            end
        end
    endtask

    task automatic test_false_start();
        int t0;
        int r0 = rises.size();
        int b0 = bhigh;
        ready = 1'b1;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (bhigh == b0) begin errors++; $display("FAIL false_busy_pulse got 0 busy cycles want >0"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_busy_idle got %b want 0", busy); end
        checks++; if (rises.size() !== r0) begin errors++; $display("FAIL false_valid got %0d want 0", rises.size() - r0); end
        send_byte(8'hA5, 1'b1, CPB, t0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rises.size() - r0 !== 1 || rises[rises.size()-1].d !== 8'hA5 ||
            rises[rises.size()-1].c !== t0 + LATENCY) begin
            errors++; $display("FAIL false_then_a5 got %0d bytes last %h want 1 byte a5 at %0d",
                               rises.size() - r0, data, LATENCY);
        end
    endtask

    task automatic test_frame_err();
        int t0;
        int r0 = rises.size();
        int f0 = ferrs.size();
        ready = 1'b1;
        send_byte(8'h3C, 1'b0, 2*CPB, t0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_held got %b want 1", busy); end
        rx = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b want 0", busy); end
        checks++;
        if (ferrs.size() - f0 !== 1) begin
            errors++; $display("FAIL ferr_count got %0d want 1", ferrs.size() - f0);
        end else begin
            checks++; if (ferrs[f0] !== t0 + LATENCY) begin errors++; $display("FAIL ferr_cycle got %0d want %0d", ferrs[f0] - t0, LATENCY); end
        end
        checks++; if (rises.size() !== r0) begin errors++; $display("FAIL ferr_valid got %0d want 0", rises.size() - r0); end
    endtask

    task automatic test_overrun();
        int t0;
        ready = 1'b0;
        send_byte(8'h11, 1'b1, CPB, t0);
        send_byte(8'h22, 1'b1, CPB, t0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (data !== 8'h11)   begin errors++; $display("FAIL ovr_data got %h want 11", data); end
        checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL ovr_valid got %b want 1", valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL ovr_accept_valid got %b want 0", valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_accept_flag got %b want 0", overrun); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b = 8'h5A;
        int r0;
        // Put a non-zero byte in data first so the reset clear is visible.
        ready = 1'b0;
        send_byte(8'hC3, 1'b1, CPB, r0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        r0 = rises.size();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (data !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got data=%h valid=%b busy=%b ferr=%b ovr=%b want all 0",
                     data, valid, busy, frame_err, overrun);
        end
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        ready = 1'b1;
        repeat (120) @(negedge clk);
        checks++; if (rises.size() !== r0) begin errors++; $display("FAIL mid_no_valid got %0d want 0", rises.size() - r0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after got %b want 0", busy); end
    endtask

    // Bench serial driver plays the transmitter side of the loopback.
    task automatic test_loopback();
        logic [7:0] msg [6] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
        int t0;
        int r0 = rises.size();
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_byte(msg[i], 1'b1, CPB, t0);
            rx = 1'b1;
            repeat (i) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (rises.size() - r0 !== 6) begin
            errors++; $display("FAIL loop_count got %0d want 6", rises.size() - r0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (rises[r0+i].d !== msg[i]) begin
                    errors++; $display("FAIL loop_byte%0d got %h want %h", i, rises[r0+i].d, msg[i]);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
